// File: rtl/oric_audio_pkg.sv
// Shared types, widths and scaling helpers for the Oric audio back-end.
package oric_audio_pkg;

    localparam int PSG_CH_W  = 12;
    localparam int PSG_MIX_W = 14;
    localparam int AUDIO_W   = 16;
    localparam int SUM_W     = PSG_CH_W + 1;

    typedef enum logic [1:0] {
        STEREO_OFF  = 2'b00,
        STEREO_ABC  = 2'b01,
        STEREO_ACB  = 2'b10,
        STEREO_ACB2 = 2'b11
    } stereo_mode_t;

    // A 13-bit channel-pair sum fills the 16-bit range with three zero LSBs.
    function automatic logic [AUDIO_W-1:0] scale_sum(input logic [SUM_W-1:0] s);
        return {s, 3'b000};
    endfunction

    // The 14-bit mono mix fills the 16-bit range with two zero LSBs.
    function automatic logic [AUDIO_W-1:0] scale_mix(input logic [PSG_MIX_W-1:0] m);
        return {m, 2'b00};
    endfunction

endpackage

// File: rtl/audio_lpf.sv
// One-pole low-pass filter channel: y <= y + ((x - y) >>> SHIFT) on each valid sample.
// The step is a fraction of the remaining distance, so y never overshoots x
// and always stays inside 0..0xFFFF.
module audio_lpf
    import oric_audio_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input  logic               clk_sys,
    input  logic               RESET,
    input  logic               valid,
    input  logic [AUDIO_W-1:0] x,
    output logic [AUDIO_W-1:0] y
);

    logic signed [AUDIO_W:0] diff;
    logic signed [AUDIO_W:0] step;

    assign diff = $signed({1'b0, x}) - $signed({1'b0, y});
    assign step = diff >>> SHIFT;

    // Accumulate the scaled difference only when a new sample arrives.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            y <= '0;
        end else if (valid) begin
            y <= AUDIO_W'($unsigned(step) + (AUDIO_W + 1)'(y));
        end
    end

endmodule

// File: rtl/oric_audio_mixer.sv
// Oric audio back-end: samples the PSG channels at a fixed rate, builds
// Off/ABC/ACB stereo pairs, scales to 16-bit unsigned and registers the result
// with a one-cycle sample strobe.
// Optional feature macro: ORIC_AUDIO_LPF_EN adds a one-pole low-pass filter per
// channel after the select/scale stage (one extra cycle of latency).
//
// Pipeline handshake: each stage carries a valid bit that is a single-cycle
// pulse; a stage loads its data registers only when the upstream valid is high
// and holds them otherwise. There is no back-pressure: SAMPLE_DIV >= 8 keeps
// ticks further apart than the pipeline is deep.
module oric_audio_mixer
    import oric_audio_pkg::*;
#(
    parameter int SAMPLE_DIV = 512,
    parameter int LPF_SHIFT  = 2
) (
    input  logic                 clk_sys,
    input  logic                 RESET,
    input  logic [PSG_CH_W-1:0]  psg_a,
    input  logic [PSG_CH_W-1:0]  psg_b,
    input  logic [PSG_CH_W-1:0]  psg_c,
    input  logic [PSG_MIX_W-1:0] psg_mix,
    input  logic [1:0]           stereo,
    input  logic                 mute,
    output logic [AUDIO_W-1:0]   audio_l,
    output logic [AUDIO_W-1:0]   audio_r,
    output logic                 sample_stb
);

    // Elaboration-time guard on the legal parameter ranges.
    if (SAMPLE_DIV < 8 || SAMPLE_DIV > 65535 || LPF_SHIFT < 1 || LPF_SHIFT > 6) begin : g_bad_params
        $error("oric_audio_mixer: SAMPLE_DIV or LPF_SHIFT out of range");
    end

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    logic [15:0] div_cnt;
    logic        tick;

    // Stage 0 holding registers.
    logic [PSG_CH_W-1:0]  hold_a;
    logic [PSG_CH_W-1:0]  hold_b;
    logic [PSG_CH_W-1:0]  hold_c;
    logic [PSG_MIX_W-1:0] hold_mix;
    stereo_mode_t         hold_mode;
    logic                 hold_mute;
    logic                 v0;

    // Stage 1 sums and carried controls.
    logic [SUM_W-1:0]     sum_ab;
    logic [SUM_W-1:0]     sum_ac;
    logic [SUM_W-1:0]     sum_bc;
    logic [PSG_MIX_W-1:0] s1_mix;
    stereo_mode_t         s1_mode;
    logic                 s1_mute;
    logic                 v1;

    // Stage 2 select/scale results.
    logic [AUDIO_W-1:0]   l_c;
    logic [AUDIO_W-1:0]   r_c;

    logic                 stb_q;

    assign tick = (div_cnt == DIV_LAST);

    // Free-running sample-rate divider, 0..SAMPLE_DIV-1.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Stage 0: snapshot all inputs on tick so mid-period changes are ignored.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            hold_a    <= '0;
            hold_b    <= '0;
            hold_c    <= '0;
            hold_mix  <= '0;
            hold_mode <= STEREO_OFF;
            hold_mute <= 1'b0;
            v0        <= 1'b0;
        end else begin
            v0 <= tick;
            if (tick) begin
                hold_a    <= psg_a;
                hold_b    <= psg_b;
                hold_c    <= psg_c;
                hold_mix  <= psg_mix;
                hold_mode <= stereo_mode_t'(stereo);
                hold_mute <= mute;
            end
        end
    end

    // Stage 1: zero-extended pair sums; 13 bits cannot overflow.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            sum_ab  <= '0;
            sum_ac  <= '0;
            sum_bc  <= '0;
            s1_mix  <= '0;
            s1_mode <= STEREO_OFF;
            s1_mute <= 1'b0;
            v1      <= 1'b0;
        end else begin
            v1 <= v0;
            if (v0) begin
                sum_ab  <= {1'b0, hold_a} + {1'b0, hold_b};
                sum_ac  <= {1'b0, hold_a} + {1'b0, hold_c};
                sum_bc  <= {1'b0, hold_b} + {1'b0, hold_c};
                s1_mix  <= hold_mix;
                s1_mode <= hold_mode;
                s1_mute <= hold_mute;
            end
        end
    end

    // Stage 2: pick the stereo pairing and scale to 16 bits; mute wins.
    always_comb begin
        l_c = '0;
        r_c = '0;
        case (s1_mode)
            STEREO_OFF: begin
                l_c = scale_mix(s1_mix);
                r_c = scale_mix(s1_mix);
            end
            STEREO_ABC: begin
                l_c = scale_sum(sum_ab);
                r_c = scale_sum(sum_bc);
            end
            default: begin
                l_c = scale_sum(sum_ac);
                r_c = scale_sum(sum_bc);
            end
        endcase
        if (s1_mute) begin
            l_c = '0;
            r_c = '0;
        end
    end

`ifdef ORIC_AUDIO_LPF_EN
    logic [AUDIO_W-1:0] x_l;
    logic [AUDIO_W-1:0] x_r;
    logic               v2;

    // Register the stage 2 result as the filter input sample.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            x_l   <= '0;
            x_r   <= '0;
            v2    <= 1'b0;
            stb_q <= 1'b0;
        end else begin
            v2    <= v1;
            stb_q <= v2;
            if (v1) begin
                x_l <= l_c;
                x_r <= r_c;
            end
        end
    end

    audio_lpf #(.SHIFT(LPF_SHIFT)) u_lpf_l (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .valid   (v2),
        .x       (x_l),
        .y       (audio_l)
    );

    audio_lpf #(.SHIFT(LPF_SHIFT)) u_lpf_r (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .valid   (v2),
        .x       (x_r),
        .y       (audio_r)
    );
`else
    logic [AUDIO_W-1:0] out_l_q;
    logic [AUDIO_W-1:0] out_r_q;

    // Output register: load the stage 2 pair and pulse the strobe.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            out_l_q <= '0;
            out_r_q <= '0;
            stb_q   <= 1'b0;
        end else begin
            stb_q <= v1;
            if (v1) begin
                out_l_q <= l_c;
                out_r_q <= r_c;
            end
        end
    end

    assign audio_l = out_l_q;
    assign audio_r = out_r_q;
`endif

    assign sample_stb = stb_q;

endmodule

// File: tb/tb_oric_audio_mixer.sv
// Directed bench for oric_audio_mixer (default build, SAMPLE_DIV = 8).
// Expected samples {l, r, strobe cycle} are queued by the driver; a monitor
// pops one on every sample_stb and otherwise checks the outputs hold steady.
module tb_oric_audio_mixer;

    localparam int DIV = 8;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic [11:0] psg_a   = '0;
    logic [11:0] psg_b   = '0;
    logic [11:0] psg_c   = '0;
    logic [13:0] psg_mix = '0;
    logic [1:0]  stereo  = '0;
    logic        mute    = 1'b0;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        sample_stb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [47:0] exp_q[$];
    logic [15:0] last_l = '0;
    logic [15:0] last_r = '0;

    oric_audio_mixer #(
        .SAMPLE_DIV (DIV),
        .LPF_SHIFT  (2)
    ) dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .psg_a      (psg_a),
        .psg_b      (psg_b),
        .psg_c      (psg_c),
        .psg_mix    (psg_mix),
        .stereo     (stereo),
        .mute       (mute),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .sample_stb (sample_stb)
    );

    // Clock and bench cycle counter (cycle 0 = first cycle after reset release).
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: pop and compare on every strobe, otherwise outputs must hold.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk_sys);
            if (RESET) begin
                last_l = '0;
                last_r = '0;
            end else if (sample_stb) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_stb cyc=%0d got l=%h r=%h, required no strobe", cyc, audio_l, audio_r);
                end else begin
                    e = exp_q.pop_front();
                    if (audio_l !== e[47:32] || audio_r !== e[31:16] || cyc != int'(e[15:0])) begin
                        errors++;
                        $display("FAIL sample got l=%h r=%h cyc=%0d, required l=%h r=%h cyc=%0d",
                                 audio_l, audio_r, cyc, e[47:32], e[31:16], e[15:0]);
                    end
                end
                last_l = audio_l;
                last_r = audio_r;
            end else begin
                checks++;
                if (audio_l !== last_l || audio_r !== last_r) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got l=%h r=%h, required l=%h r=%h",
                             cyc, audio_l, audio_r, last_l, last_r);
                end
            end
        end
    end

    // Driver: change inputs two cycles after a tick; the next tick captures them
    // and the strobe follows three cycles after that tick.
    task automatic drive(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                         input logic [13:0] mix, input logic [1:0] st, input logic m,
                         input logic [15:0] el, input logic [15:0] er);
        int n = 0;
        @(negedge clk_sys);
        while (!(cyc % DIV == 1 && cyc > DIV) && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL drive_timeout cyc=%0d, required phase-1 slot within 100 cycles", cyc);
        end
        psg_a   = a;
        psg_b   = b;
        psg_c   = c;
        psg_mix = mix;
        stereo  = st;
        mute    = m;
        exp_q.push_back({el, er, 16'(cyc + DIV + 1)});
    endtask

    task automatic wait_cycle(input int target);
        int n = 0;
        while (cyc != target && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_timeout cyc=%0d, required cyc=%0d", cyc, target);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending samples, required 0", exp_q.size());
        end
    endtask

    initial begin
        // Reset with the first sample's inputs already applied.
        psg_a  = 12'hFFF;
        psg_b  = 12'hFFF;
        psg_c  = 12'h000;
        stereo = 2'b01;
        repeat (3) @(negedge clk_sys);
        checks++;
        if (audio_l !== 16'h0 || audio_r !== 16'h0 || sample_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got l=%h r=%h stb=%b, required 0 0 0", audio_l, audio_r, sample_stb);
        end
        exp_q.push_back({16'hFFF0, 16'h7FF8, 16'd10});
        RESET = 1'b0;

        // Mono mix full scale, then ACB with distinct channels.
        drive(12'h000, 12'h000, 12'h000, 14'h3FFF, 2'b00, 1'b0, 16'hFFFC, 16'hFFFC);
        drive(12'h100, 12'h200, 12'h300, 14'h0000, 2'b10, 1'b0, 16'h2000, 16'h2800);
        // Mid-period changes: each takes effect only one sample later.
        drive(12'h000, 12'h200, 12'h300, 14'h0000, 2'b01, 1'b0, 16'h1000, 16'h2800);
        drive(12'hFFF, 12'h200, 12'h300, 14'h0000, 2'b10, 1'b0, 16'h97F8, 16'h2800);
        // Mode 11 behaves as ACB.
        drive(12'h001, 12'h002, 12'h003, 14'h0000, 2'b11, 1'b0, 16'h0020, 16'h0028);
        // Mute with full-scale inputs in ABC and Off, then release.
        drive(12'hFFF, 12'hFFF, 12'hFFF, 14'h3FFF, 2'b01, 1'b1, 16'h0000, 16'h0000);
        drive(12'hFFF, 12'hFFF, 12'hFFF, 14'h3FFF, 2'b00, 1'b1, 16'h0000, 16'h0000);
        drive(12'hFFF, 12'hFFF, 12'hFFF, 14'h3FFF, 2'b01, 1'b0, 16'hFFF0, 16'hFFF0);
        drain();

        // Reset one cycle after the tick at cycle 79: that sample must vanish.
        wait_cycle(80);
        RESET   = 1'b1;
        psg_a   = 12'h001;
        psg_b   = 12'h000;
        psg_c   = 12'h000;
        psg_mix = 14'h0000;
        stereo  = 2'b01;
        mute    = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (audio_l !== 16'h0 || audio_r !== 16'h0 || sample_stb !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got l=%h r=%h stb=%b, required 0 0 0", audio_l, audio_r, sample_stb);
        end
        exp_q.push_back({16'h0008, 16'h0000, 16'd10});
        exp_q.push_back({16'h0008, 16'h0000, 16'd18});
        RESET = 1'b0;
        drain();
        repeat (4) @(negedge clk_sys);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
